// File: rtl/uart_rx_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   uart_state_t    - receiver FSM states
//   UART_DATA_BITS  - data bits per frame
//   UART_IDLE_LEVEL - line level while idle (also the synchronizer reset value)
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    ERR,
    BREAK
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous input pin.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high; both flops load RESET_VALUE
//   d     - asynchronous input
//   q     - synchronized output (two clk cycles of latency)
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter logic RESET_VALUE = UART_IDLE_LEVEL
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver.
// Ports:
//   clk        - clock, all logic on posedge
//   reset      - synchronous, active-high
//   rx         - asynchronous serial line, idles high
//   data_out   - last correctly received byte
//   rx_done    - one-cycle pulse when data_out is updated
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   parity_err - one-cycle pulse on parity mismatch (constant 0 unless built
//                with UART_RX_PARITY_EN)
//   busy       - high whenever the receiver is not idle
// Build option: define UART_RX_PARITY_EN to expect a parity bit between the
// data and stop bits (even parity, or odd when PARITY_ODD=1).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      rx_done,
  output logic                      frame_err,
  output logic                      parity_err,
  output logic                      busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Counter terminal values: the start bit is sampled half a bit in, every
  // later bit a full bit after the previous sample (i.e. mid-bit).
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t               state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      rx_s;

  uart_rx_sync #(
    .RESET_VALUE(UART_IDLE_LEVEL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bad;
  assign par_bad = par_bit != ((^shreg) ^ PARITY_ODD);
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = PARITY_ODD;
  assign parity_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rx_s != UART_IDLE_LEVEL) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (rx_s == UART_IDLE_LEVEL) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        // Pulses are registered on the transition so they are high during
        // the one-cycle DONE/ERR slot that follows the stop sample.
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s == UART_IDLE_LEVEL) begin
              state <= DONE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
                rx_done  <= 1'b1;
                data_out <= shreg;
              end
`else
              rx_done  <= 1'b1;
              data_out <= shreg;
`endif
            end else begin
              state     <= ERR;
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        ERR: begin
          state <= BREAK;
        end

        // A held-low line stays here, so a break yields a single frame_err.
        BREAK: begin
          if (rx_s == UART_IDLE_LEVEL) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
